// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//   Single-ported memory bus between the fetch/data arbiter and the memory.
//   One request channel (valid/ready with doubleword address and store
//   qualifiers) and one in-order response strobe with data.
//
//   master : arbiter side (drives requests, receives responses)
//   slave  : memory side  (accepts requests, drives responses)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_we;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch and data load/store.
//   Fetches are served from a one-doubleword fetch buffer; a miss refills it.
//   At most one memory request is outstanding at any time.
//
//   Parameter DATA_PRIO : 1 = data wins when fetch miss and data are both
//                         pending, 0 = fetch wins.
//   Macro ARB_STORE_SNOOP_EN : when defined, an accepted store to the
//                         buffered doubleword invalidates the fetch buffer.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     if_request, pc       fetch request / 4-byte aligned fetch address
//     inst, if_stall       instruction word / fetch not yet satisfied
//     re_mem, we_mem       data load / store request
//     address              data byte address
//     wdata_mem, wmask_mem lane-positioned store data / byte enables
//     rdata_mem, mem_stall load doubleword (unshifted) / data access busy
//     mem                  memory bus (master modport)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_request,
  input  logic [63:0] pc,
  output logic [31:0] inst,
  output logic        if_stall,
  input  logic        re_mem,
  input  logic        we_mem,
  input  logic [63:0] address,
  input  logic [63:0] wdata_mem,
  input  logic [7:0]  wmask_mem,
  output logic [63:0] rdata_mem,
  output logic        mem_stall,
  mem_port_arbiter_if.master mem
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    D_REQ   = 3'd3,
    D_WAIT  = 3'd4,
    D_DONE  = 3'd5
  } state_t;

  // Request fields captured when leaving IDLE and held until accepted.
  // Fetch and load requests carry zero store qualifiers.
  typedef struct packed {
    logic [60:0] dw;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mem_req_t;

  state_t      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        buf_vld_q, buf_vld_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic [63:0] rdata_q, rdata_d;

  logic hit, fetch_miss, data_pend, snoop_hit, req_valid;

  // pc[1:0] and address[2:0] carry no information for doubleword access
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], address[2:0]};

  assign hit        = buf_vld_q & (buf_tag_q == pc[63:3]);
  assign fetch_miss = if_request & ~hit;
  assign data_pend  = re_mem | we_mem;

`ifdef ARB_STORE_SNOOP_EN
  // A store to the buffered doubleword makes the buffered copy stale.
  assign snoop_hit = req_q.we & (req_q.dw == buf_tag_q);
`else
  // Stores never touch the fetch buffer.
  assign snoop_hit = 1'b0;
`endif

  // Core-facing outputs
  assign inst      = pc[2] ? buf_data_q[63:32] : buf_data_q[31:0];
  assign if_stall  = if_request & ~hit;
  assign mem_stall = data_pend & (state_q != D_DONE);
  assign rdata_mem = rdata_q;

  // Memory-facing outputs
  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = {req_q.dw, 3'b000};
  assign mem.mem_req_we    = req_q.we;
  assign mem.mem_req_wdata = req_q.wdata;
  assign mem.mem_req_wmask = req_q.wmask;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    buf_vld_d  = buf_vld_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    rdata_d    = rdata_q;
    req_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_miss && (!data_pend || !DATA_PRIO)) begin
          state_d = IF_REQ;
          req_d   = '{dw: pc[63:3], we: 1'b0, wdata: '0, wmask: '0};
        end else if (data_pend) begin
          state_d = D_REQ;
          req_d   = '{dw:    address[63:3],
                      we:    we_mem,
                      wdata: we_mem ? wdata_mem : 64'd0,
                      wmask: we_mem ? wmask_mem : 8'd0};
        end
      end

      IF_REQ: begin
        req_valid = 1'b1;
        if (mem.mem_req_ready) state_d = IF_WAIT;
      end

      // Tag comes from the captured request, not the live pc: a fetch that
      // was abandoned or redirected still fills with the line it asked for.
      IF_WAIT: begin
        if (mem.mem_resp_valid) begin
          buf_data_d = mem.mem_resp_data;
          buf_tag_d  = req_q.dw;
          buf_vld_d  = 1'b1;
          state_d    = IDLE;
        end
      end

      D_REQ: begin
        req_valid = 1'b1;
        if (mem.mem_req_ready) begin
          state_d = D_WAIT;
          if (snoop_hit) buf_vld_d = 1'b0;
        end
      end

      D_WAIT: begin
        if (mem.mem_resp_valid) begin
          rdata_d = mem.mem_resp_data;
          state_d = D_DONE;
        end
      end

      // One-cycle completion window: mem_stall drops here only.
      D_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      buf_vld_q  <= 1'b0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      buf_vld_q  <= buf_vld_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
      rdata_q    <= rdata_d;
    end
  end

  // A stalled request must not change under the memory's feet.
  a_req_hold: assert property (@(posedge clk) disable iff (!rstn)
    (req_valid && !mem.mem_req_ready) |=>
      (req_valid && $stable(req_q)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
`ifdef ARB_STORE_SNOOP_EN
  localparam bit SNOOP = 1'b1;
`else
  localparam bit SNOOP = 1'b0;
`endif

  logic        clk;
  logic        rstn;
  logic        if_request;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        if_stall;
  logic        re_mem, we_mem;
  logic [63:0] address, wdata_mem, rdata_mem;
  logic [7:0]  wmask_mem;
  logic        mem_stall;

  mem_port_arbiter_if mem_bus();

  mem_port_arbiter #(.DATA_PRIO(1'b1)) dut (
    .clk(clk), .rstn(rstn),
    .if_request(if_request), .pc(pc), .inst(inst), .if_stall(if_stall),
    .re_mem(re_mem), .we_mem(we_mem), .address(address),
    .wdata_mem(wdata_mem), .wmask_mem(wmask_mem),
    .rdata_mem(rdata_mem), .mem_stall(mem_stall),
    .mem(mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- memory model ----------------
  logic [63:0] mem_img [logic [60:0]];

  function automatic logic [63:0] mem_rd(input logic [60:0] idx);
    if (mem_img.exists(idx)) return mem_img[idx];
    return {idx[31:0] ^ 32'h5a5a_0f0f, ~idx[31:0]};
  endfunction

  int          rdy_block = 0;
  bit          rdy_rand  = 1'b0;
  int          resp_dly  = 1;
  bit          dly_rand  = 1'b0;
  int          resp_cnt  = 0;
  logic [63:0] resp_buf  = '0;
  int          nreq      = 0;
  logic [63:0] log_addr[$];
  logic        log_we[$];
  logic [63:0] log_wdata[$];
  logic [7:0]  log_wmask[$];

  initial begin
    logic [60:0] idx;
    logic [63:0] cur;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_bus.mem_resp_valid = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_bus.mem_resp_valid = 1'b1;
          mem_bus.mem_resp_data  = resp_buf;
        end
      end
      if (rdy_block > 0) begin
        rdy_block--;
        mem_bus.mem_req_ready = 1'b0;
      end else begin
        mem_bus.mem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (mem_bus.mem_req_valid && mem_bus.mem_req_ready) begin
        idx = mem_bus.mem_req_addr[63:3];
        log_addr.push_back(mem_bus.mem_req_addr);
        log_we.push_back(mem_bus.mem_req_we);
        log_wdata.push_back(mem_bus.mem_req_wdata);
        log_wmask.push_back(mem_bus.mem_req_wmask);
        nreq++;
        if (mem_bus.mem_req_we) begin
          cur = mem_rd(idx);
          for (int b = 0; b < 8; b++)
            if (mem_bus.mem_req_wmask[b]) cur[b*8 +: 8] = mem_bus.mem_req_wdata[b*8 +: 8];
          mem_img[idx] = cur;
          resp_buf = '0;
        end else begin
          resp_buf = mem_rd(idx);
        end
        resp_cnt = dly_rand ? int'($urandom_range(1, 3)) : resp_dly;
      end
    end
  end

  // ---------------- driver: one core operation, returns observations -------
  task automatic do_op(input bit f_en, input logic [63:0] f_pc,
                       input bit d_en, input bit d_we, input logic [63:0] d_addr,
                       input logic [63:0] d_wdata, input logic [7:0] d_wmask,
                       output int f_lat, output int d_lat,
                       output logic [31:0] f_inst, output logic [63:0] d_rdata);
    bit f_act, d_act;
    @(negedge clk);
    if_request = f_en;  pc = f_pc;
    re_mem = d_en & ~d_we;  we_mem = d_en & d_we;
    address = d_addr;  wdata_mem = d_wdata;  wmask_mem = d_wmask;
    f_act = f_en;  d_act = d_en;
    f_lat = -1;  d_lat = -1;  f_inst = '0;  d_rdata = '0;
    for (int cyc = 0; cyc < 200 && (f_act || d_act); cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (f_act && !if_stall) begin
        f_inst = inst;  f_lat = cyc;  f_act = 1'b0;  if_request = 1'b0;
      end
      if (d_act && !mem_stall) begin
        d_rdata = rdata_mem;  d_lat = cyc;  d_act = 1'b0;  re_mem = 1'b0;  we_mem = 1'b0;
      end
    end
    if_request = 1'b0;  re_mem = 1'b0;  we_mem = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;  if_request = 1'b1;  pc = 64'h100;  re_mem = 1'b1;  we_mem = 1'b0;
    address = '0;  wdata_mem = '0;  wmask_mem = '0;
    @(negedge clk); @(negedge clk); #1;
    total++; if (mem_bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", mem_bus.mem_req_valid); end
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL rst_if_stall got=%b want=1", if_stall); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h want=0", inst); end
    total++; if (rdata_mem !== 64'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata_mem); end
    total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL rst_mem_stall got=%b want=1", mem_stall); end
    @(negedge clk);
    if_request = 1'b0;  re_mem = 1'b0;  rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_buffer();
    int fl, dl, n0;  logic [31:0] fi;  logic [63:0] dr;
    mem_img[61'h100 >> 3] = 64'h0000_0013_0000_0093;
    n0 = nreq;
    do_op(1, 64'h100, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (fl !== 3) begin bad++; $display("FAIL fetch_miss_lat got=%0d want=3", fl); end
    total++; if (fi !== 32'h0000_0093) begin bad++; $display("FAIL fetch_inst_lo got=%h want=00000093", fi); end
    total++; if (nreq - n0 !== 1 || log_addr[n0] !== 64'h100) begin bad++; $display("FAIL fetch_req got_n=%0d want_n=1", nreq - n0); end
    n0 = nreq;
    do_op(1, 64'h104, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (fl !== 0) begin bad++; $display("FAIL fetch_hit_lat got=%0d want=0", fl); end
    total++; if (fi !== 32'h0000_0013) begin bad++; $display("FAIL fetch_inst_hi got=%h want=00000013", fi); end
    total++; if (nreq !== n0) begin bad++; $display("FAIL fetch_hit_noreq got=%0d want=0", nreq - n0); end
  endtask

  task automatic test_data_prio();
    int fl, dl, n0;  logic [31:0] fi;  logic [63:0] dr, exp_ld, exp_line;
    exp_ld   = mem_rd(61'h2008 >> 3);
    exp_line = mem_rd(61'h140 >> 3);
    n0 = nreq;
    do_op(1, 64'h140, 1, 0, 64'h2008, 64'hffff, 8'hff, fl, dl, fi, dr);
    total++; if (dl !== 3) begin bad++; $display("FAIL prio_data_lat got=%0d want=3", dl); end
    total++; if (dr !== exp_ld) begin bad++; $display("FAIL prio_rdata got=%h want=%h", dr, exp_ld); end
    total++; if (nreq - n0 !== 2) begin bad++; $display("FAIL prio_nreq got=%0d want=2", nreq - n0); end
    else begin
      total++; if (log_addr[n0] !== 64'h2008 || log_we[n0] !== 1'b0)
        begin bad++; $display("FAIL prio_first_req got=%h want=2008", log_addr[n0]); end
      total++; if (log_wdata[n0] !== 64'h0 || log_wmask[n0] !== 8'h0)
        begin bad++; $display("FAIL load_zero_qual got=%h/%h want=0/0", log_wdata[n0], log_wmask[n0]); end
      total++; if (log_addr[n0+1] !== 64'h140)
        begin bad++; $display("FAIL prio_second_req got=%h want=140", log_addr[n0+1]); end
    end
    total++; if (fl !== 7) begin bad++; $display("FAIL prio_fetch_lat got=%0d want=7", fl); end
    total++; if (fi !== exp_line[31:0]) begin bad++; $display("FAIL prio_inst got=%h want=%h", fi, exp_line[31:0]); end
  endtask

  task automatic test_store_hold();
    int n0, held, fin;  bit ok;
    @(negedge clk);
    n0 = nreq;  rdy_block = 4;
    we_mem = 1'b1;  address = 64'h3004;  wdata_mem = 64'hAABBCCDD_00000000;  wmask_mem = 8'hF0;
    held = 0;  ok = 1'b1;  fin = -1;
    for (int cyc = 1; cyc < 40 && fin < 0; cyc++) begin
      @(negedge clk); #1;
      if (mem_bus.mem_req_valid) begin
        held++;
        if (mem_bus.mem_req_addr !== 64'h3000 || mem_bus.mem_req_we !== 1'b1 ||
            mem_bus.mem_req_wdata !== 64'hAABBCCDD_00000000 || mem_bus.mem_req_wmask !== 8'hF0) ok = 1'b0;
      end
      if (!mem_stall) begin fin = cyc; we_mem = 1'b0; end
    end
    we_mem = 1'b0;
    total++; if (held !== 5) begin bad++; $display("FAIL store_hold_cycles got=%0d want=5", held); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL store_fields got=%b want=1", ok); end
    total++; if (fin !== 7) begin bad++; $display("FAIL store_done_lat got=%0d want=7", fin); end
    total++; if (nreq - n0 !== 1) begin bad++; $display("FAIL store_nreq got=%0d want=1", nreq - n0); end
  endtask

  task automatic test_reset_mid_fetch();
    int fl, dl, n0;  logic [31:0] fi;  logic [63:0] dr, exp_line;
    @(negedge clk);
    resp_dly = 3;  n0 = nreq;
    if_request = 1'b1;  pc = 64'h180;
    @(negedge clk);                       // IF_REQ, accepted this cycle
    @(negedge clk);                       // IF_WAIT
    pc = 64'h140;  #1;                    // redirect to the line still buffered
    total++; if (if_stall !== 1'b0) begin bad++; $display("FAIL midflight_hit got=%b want=0", if_stall); end
    rstn = 1'b0;  #1;
    total++; if (if_stall !== 1'b1) begin bad++; $display("FAIL rst_async_buf got=%b want=1", if_stall); end
    total++; if (mem_bus.mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%b want=0", mem_bus.mem_req_valid); end
    @(negedge clk);
    if_request = 1'b0;  rstn = 1'b1;
    repeat (3) @(negedge clk);            // stale response lands while idle
    resp_dly = 1;
    total++; if (nreq - n0 !== 1) begin bad++; $display("FAIL rst_stale_nreq got=%0d want=1", nreq - n0); end
    exp_line = mem_rd(61'h140 >> 3);
    n0 = nreq;
    do_op(1, 64'h140, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (nreq - n0 !== 1 || fl !== 3) begin bad++; $display("FAIL rst_buf_cleared got_n=%0d lat=%0d want_n=1 lat=3", nreq - n0, fl); end
    total++; if (fi !== exp_line[31:0]) begin bad++; $display("FAIL rst_refetch_inst got=%h want=%h", fi, exp_line[31:0]); end
    exp_line = mem_rd(61'h180 >> 3);
    n0 = nreq;
    do_op(1, 64'h184, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (nreq - n0 !== 1 || log_addr[n0] !== 64'h180) begin bad++; $display("FAIL rst_reissue got_n=%0d want_n=1", nreq - n0); end
    total++; if (fi !== exp_line[63:32]) begin bad++; $display("FAIL rst_reissue_inst got=%h want=%h", fi, exp_line[63:32]); end
  endtask

  task automatic test_snoop();
    int fl, dl, n0;  logic [31:0] fi;  logic [63:0] dr;
    do_op(1, 64'h100, 0, 0, 0, 0, 0, fl, dl, fi, dr);   // buffer now holds 0x100
    do_op(0, 0, 1, 1, 64'h104, 64'hDEADBEEF_00000000, 8'hF0, fl, dl, fi, dr);
    n0 = nreq;
    do_op(1, 64'h100, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (nreq - n0 !== (SNOOP ? 1 : 0)) begin bad++; $display("FAIL snoop_nreq got=%0d want=%0d", nreq - n0, SNOOP ? 1 : 0); end
    total++; if (fi !== 32'h0000_0093) begin bad++; $display("FAIL snoop_inst_lo got=%h want=00000093", fi); end
    n0 = nreq;
    do_op(1, 64'h104, 0, 0, 0, 0, 0, fl, dl, fi, dr);
    total++; if (fi !== (SNOOP ? 32'hDEADBEEF : 32'h0000_0013)) begin bad++; $display("FAIL snoop_inst_hi got=%h want=%h", fi, SNOOP ? 32'hDEADBEEF : 32'h0000_0013); end
    total++; if (nreq !== n0) begin bad++; $display("FAIL snoop_hit_noreq got=%0d want=0", nreq - n0); end
  endtask

  task automatic test_random();
    int fl, dl, n0, kind, exp_n;  logic [31:0] fi;  logic [63:0] dr;
    bit f_en, d_en, d_we, f_hit, m_vld;
    logic [60:0] m_tag;  logic [63:0] m_data, f_pc, d_addr, d_wdata, exp_ld, exp_line;
    logic [7:0] d_wmask;
    rdy_rand = 1'b1;  dly_rand = 1'b1;
    m_vld = 1'b0;  m_tag = '0;  m_data = '0;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      f_en = (kind == 0 || kind >= 3);
      d_en = (kind != 0);
      d_we = (kind == 2 || kind == 4);
      f_pc    = 64'h200 + 64'(8 * $urandom_range(0, 3)) + 64'(4 * $urandom_range(0, 1));
      d_addr  = 64'h2000 + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
      d_wdata = {$urandom, $urandom};
      d_wmask = 8'($urandom_range(1, 255));
      f_hit   = m_vld && (m_tag == f_pc[63:3]);
      exp_ld  = mem_rd(d_addr[63:3]);
      exp_n   = (d_en ? 1 : 0) + ((f_en && !f_hit) ? 1 : 0);
      n0 = nreq;
      do_op(f_en, f_pc, d_en, d_we, d_addr, d_wdata, d_wmask, fl, dl, fi, dr);
      total++; if (nreq - n0 !== exp_n) begin bad++; $display("FAIL rnd_nreq it=%0d got=%0d want=%0d", it, nreq - n0, exp_n); end
      if (d_en) begin
        total++; if (dl < 0) begin bad++; $display("FAIL rnd_data_timeout it=%0d got=%0d want>=0", it, dl); end
        if (!d_we) begin
          total++; if (dr !== exp_ld) begin bad++; $display("FAIL rnd_rdata it=%0d got=%h want=%h", it, dr, exp_ld); end
        end
        if (nreq - n0 == exp_n) begin
          total++; if (log_addr[n0] !== {d_addr[63:3], 3'b000} || log_we[n0] !== d_we)
            begin bad++; $display("FAIL rnd_data_first it=%0d got=%h want=%h", it, log_addr[n0], {d_addr[63:3], 3'b000}); end
        end
        if (d_we && SNOOP && m_vld && m_tag == d_addr[63:3]) m_vld = 1'b0;
      end
      if (f_en) begin
        exp_line = f_hit ? m_data : mem_rd(f_pc[63:3]);
        total++; if (fl < 0) begin bad++; $display("FAIL rnd_fetch_timeout it=%0d got=%0d want>=0", it, fl); end
        total++; if (fi !== (f_pc[2] ? exp_line[63:32] : exp_line[31:0]))
          begin bad++; $display("FAIL rnd_inst it=%0d got=%h want=%h", it, fi, f_pc[2] ? exp_line[63:32] : exp_line[31:0]); end
        if (!f_hit) begin m_vld = 1'b1; m_tag = f_pc[63:3]; m_data = exp_line; end
      end
    end
    rdy_rand = 1'b0;  dly_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_buffer();
    test_data_prio();
    test_store_hold();
    test_reset_mid_fetch();
    test_snoop();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
